// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external 2-port RAM (port 1 write, port 2 read).
// A 2-entry register buffer hides the RAM's registered read latency.
module ram_fifo_ctrl #(
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned WORD_BITS = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_wr_valid,
  output logic                 out_wr_ready,
  input  logic [WORD_BITS-1:0] in_wr_data,
  output logic                 out_rd_valid,
  input  logic                 in_rd_ready,
  output logic [WORD_BITS-1:0] out_rd_data,
  output logic [ADDR_BITS+1:0] out_count,
  output logic                 out_full,
  output logic                 out_empty,
  output logic                 out_ram_write_ena,
  output logic [ADDR_BITS-1:0] out_ram_addr_w,
  output logic [WORD_BITS-1:0] out_ram_data_w,
  output logic                 out_ram_read_ena,
  output logic [ADDR_BITS-1:0] out_ram_addr_r,
  input  logic [WORD_BITS-1:0] in_ram_data_r
);

  localparam int unsigned PTR_BITS = ADDR_BITS + 1;
  localparam int unsigned CNT_BITS = ADDR_BITS + 2;
  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;

  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [PTR_BITS-1:0]  ram_count;
  logic                 inflight;
  logic [1:0]           buf_occ;
  logic [WORD_BITS-1:0] buf_head;
  logic [WORD_BITS-1:0] buf_tail;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [2:0]           occ_after;

  assign ram_count    = wr_ptr - rd_ptr;
  assign out_wr_ready = (ram_count < PTR_BITS'(DEPTH));
  assign out_full     = (ram_count == PTR_BITS'(DEPTH));

  // Push is gated by reset so the RAM write enable stays low while in reset.
  assign push         = in_wr_valid && out_wr_ready && !in_rst;
  assign out_rd_valid = (buf_occ != 2'd0);
  assign pop          = out_rd_valid && in_rd_ready;

  // Buffer occupancy after this edge; issue only if the returning word will fit.
  assign occ_after = 3'(buf_occ) + 3'(inflight) - 3'(pop);
  assign issue     = (ram_count != '0) && (occ_after <= 3'd1);

  assign out_ram_write_ena = push;
  assign out_ram_addr_w    = wr_ptr[ADDR_BITS-1:0];
  assign out_ram_data_w    = in_wr_data;
  assign out_ram_read_ena  = issue;
  assign out_ram_addr_r    = rd_ptr[ADDR_BITS-1:0];

  assign out_rd_data = buf_head;
  assign out_count   = CNT_BITS'(ram_count) + CNT_BITS'(inflight) + CNT_BITS'(buf_occ);
  assign out_empty   = (out_count == '0);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      buf_occ  <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_BITS'(1);
      inflight <= issue;
      buf_occ  <= occ_after[1:0];
      // Shift-register buffer: head is always the oldest word.
      unique case ({inflight, pop})
        2'b10: begin
          if (buf_occ == 2'd0) buf_head <= in_ram_data_r;
          else buf_tail <= in_ram_data_r;
        end
        2'b01: buf_head <= buf_tail;
        2'b11: begin
          if (buf_occ == 2'd2) begin
            buf_head <= buf_tail;
            buf_tail <= in_ram_data_r;
          end else begin
            buf_head <= in_ram_data_r;
          end
        end
        default: ;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge in_clk) disable iff (in_rst) occ_after <= 3'd2);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 2-port RAM model.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ram_we;
  logic [2:0] ram_aw;
  logic [7:0] ram_dw;
  logic       ram_re;
  logic [2:0] ram_ar;
  logic [7:0] ram_q;
  logic [7:0] mem [8];

  int checks = 0;
  int failures = 0;
  int n_pop = 0;
  logic [7:0] last_pop = 8'h00;
  logic [7:0] exp_q [$];
  logic [2:0] prev_w = 3'd0;
  logic [2:0] prev_r = 3'd0;
  logic have_w = 1'b0;
  logic have_r = 1'b0;
  logic wrap_w = 1'b0;
  logic wrap_r = 1'b0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_BITS(3), .WORD_BITS(8)) dut (
    .in_clk(clk), .in_rst(rst),
    .in_wr_valid(wr_valid), .out_wr_ready(wr_ready), .in_wr_data(wr_data),
    .out_rd_valid(rd_valid), .in_rd_ready(rd_ready), .out_rd_data(rd_data),
    .out_count(count), .out_full(full), .out_empty(empty),
    .out_ram_write_ena(ram_we), .out_ram_addr_w(ram_aw), .out_ram_data_w(ram_dw),
    .out_ram_read_ena(ram_re), .out_ram_addr_r(ram_ar), .in_ram_data_r(ram_q)
  );

  // External RAM: write port 1, registered read port 2.
  always @(posedge clk) begin
    if (ram_we) mem[ram_aw] <= ram_dw;
    if (ram_re) ram_q <= mem[ram_ar];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
        end else begin
          chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        n_pop++;
        last_pop = rd_data;
      end
      if (ram_we) begin
        if (have_w && prev_w == 3'd7 && ram_aw == 3'd0) wrap_w = 1'b1;
        prev_w = ram_aw;
        have_w = 1'b1;
      end
      if (ram_re) begin
        if (have_r && prev_r == 3'd7 && ram_ar == 3'd0) wrap_r = 1'b1;
        prev_r = ram_ar;
        have_r = 1'b1;
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_valid = v;
    wr_data  = d;
    rd_ready = r;
    #4;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_re"}, 32'(ram_re), 0);
  endtask

  initial begin
    int acc, tries, n0, vcnt, first, last, viol, k, cyc;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single word through an empty FIFO
    n0 = n_pop;
    drive(1'b1, 8'hA5, 1'b1);
    for (int c = 0; c < 8; c++) drive(1'b0, 8'h00, 1'b1);
    chk("single_pops", 32'(n_pop - n0), 1);
    chk("single_last", 32'(last_pop), 32'h00A5);
    chk("single_empty", 32'(empty), 1);

    // Fill with consumer stalled: DEPTH+2 words accepted
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      tries = 0;
      do begin
        drive(1'b1, 8'(i), 1'b0);
        tries++;
      end while (!wr_ready && tries < 4);
      if (wr_ready) acc++;
    end
    chk("fill_no_write", 32'(ram_we), 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("fill_accepted", 32'(acc), 10);
    chk("fill_count", 32'(count), 10);
    chk("fill_full", 32'(full), 1);
    chk("fill_wr_ready", 32'(wr_ready), 0);

    // Drain: 10 consecutive pops with no gaps
    n0 = n_pop; vcnt = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (rd_valid) begin
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("drain_pops", 32'(n_pop - n0), 10);
    chk("drain_span", 32'(last - first + 1), 10);
    chk("drain_valid_cycles", 32'(vcnt), 10);
    chk("drain_empty", 32'(empty), 1);

    // Streaming: both sides active, count settles at 3
    n0 = n_pop; viol = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (!wr_ready) viol++;
      if (i >= 3 && count != 5'd3) viol++;
    end
    for (int c = 0; c < 8; c++) drive(1'b0, 8'h00, 1'b1);
    chk("stream_count_viol", 32'(viol), 0);
    chk("stream_pops", 32'(n_pop - n0), 100);
    chk("stream_empty", 32'(empty), 1);

    // Random bursts across pointer wrap
    k = 0; cyc = 0;
    while (k < 40 && cyc < 1000) begin
      drive(($urandom_range(0, 2) != 0), 8'(8'h40 + k), 1'($urandom_range(0, 1)));
      if (wr_valid && wr_ready) k++;
      cyc++;
    end
    chk("rand_words", 32'(k), 40);
    for (int c = 0; c < 20; c++) drive(1'b0, 8'h00, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_empty", 32'(empty), 1);
    chk("wrap_addr_w", 32'(wrap_w), 1);
    chk("wrap_addr_r", 32'(wrap_r), 1);

    // Asynchronous reset mid-stream with buffer full and RAM occupied
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h90 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(count), 6);
    @(posedge clk);
    #2;
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h77;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    n0 = n_pop;
    drive(1'b1, 8'h3C, 1'b1);
    for (int c = 0; c < 6; c++) drive(1'b0, 8'h00, 1'b1);
    chk("post_rst_pops", 32'(n_pop - n0), 1);
    chk("post_rst_first", 32'(last_pop), 32'h003C);
    chk("post_rst_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
